// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - command sequencer and accumulator for the 32-bit calculator ALU
// Optional res_zero/res_neg flag outputs are enabled by defining CALC_SEQ_FLAGS_EN.
module calc_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_load,
  input  logic [RPT_W-1:0] cmd_rpt,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef CALC_SEQ_FLAGS_EN
  output logic             res_zero,
  output logic             res_neg,
`endif
  output logic             res_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS = 3'd2;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [RPT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               in_exec;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign in_exec = (state_q == S_EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = cmd_load ? S_DONE : S_EXEC;
      S_EXEC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outside EXEC the ALU is parked on PASS with b=0 so its output just mirrors acc.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    res_valid  = (state_q == S_DONE);
    alu_opcode = in_exec ? op_q : OP_PASS;
    alu_b      = in_exec ? operand_q : '0;
  end

  assign alu_a     = acc_q;
  assign res_data  = acc_q;
  assign res_carry = carry_q;

  always_comb begin
    acc_d     = acc_q;
    carry_d   = carry_q;
    op_d      = op_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    if (accept) begin
      op_d      = cmd_opcode;
      operand_d = cmd_operand;
      cnt_d     = cmd_rpt;
      if (cmd_load) begin
        acc_d   = cmd_operand;
        carry_d = 1'b0;
      end
    end else if (in_exec) begin
      acc_d = alu_y;
      // Only the arithmetic ops (DEC/ADD/SUB/INC, opcode MSB set) drive a meaningful Cout.
      if (op_q[2]) carry_d = alu_cout;
      if (cnt_q != '0) cnt_d = cnt_q - {{(RPT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      carry_q   <= 1'b0;
      op_q      <= 3'd0;
      operand_q <= '0;
      cnt_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef CALC_SEQ_FLAGS_EN
  logic zero_q, neg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (accept || in_exec) begin
      zero_q <= (acc_d == '0);
      neg_q  <= acc_d[WIDTH-1];
    end
  end

  assign res_zero = zero_q;
  assign res_neg  = neg_q;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - self-checking bench for calc_op_sequencer with behavioural ALU
module tb_calc_op_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode = 3'd0;
  logic [W-1:0]  cmd_operand = '0;
  logic          cmd_load = 1'b0;
  logic [3:0]    cmd_rpt = 4'd0;
  logic [2:0]    alu_opcode;
  logic [W-1:0]  alu_a, alu_b, alu_y;
  logic          alu_cout;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic          res_carry;
`ifdef CALC_SEQ_FLAGS_EN
  logic          res_zero, res_neg;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_acc = '0;
  logic         m_carry = 1'b0;
  logic         junk = 1'b0;
  logic [W:0]   alu_tmp;

  always #5 clk = ~clk;

  calc_op_sequencer #(.WIDTH(W), .RPT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_operand(cmd_operand), .cmd_load(cmd_load), .cmd_rpt(cmd_rpt),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef CALC_SEQ_FLAGS_EN
    .res_zero(res_zero), .res_neg(res_neg),
`endif
    .res_carry(res_carry)
  );

  // Logic ops drive a random Cout, which the sequencer must ignore.
  always @(negedge clk) junk <= 1'($urandom);

  always_comb begin
    alu_tmp = {junk, alu_a};
    case (alu_opcode)
      3'd0: alu_tmp = {junk, ~alu_a};
      3'd1: alu_tmp = {junk, alu_a & alu_b};
      3'd2: alu_tmp = {junk, alu_a};
      3'd3: alu_tmp = {junk, alu_a | alu_b};
      3'd4: alu_tmp = {1'b0, alu_a} - 33'd1;
      3'd5: alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
      3'd6: alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
      3'd7: alu_tmp = {1'b0, alu_a} + 33'd1;
      default: alu_tmp = {junk, alu_a};
    endcase
  end
  assign alu_y    = alu_tmp[W-1:0];
  assign alu_cout = alu_tmp[W];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input logic load, input logic [2:0] op, input logic [W-1:0] opd,
                           input int rpt);
    logic [W-1:0] nxt;
    if (load) begin
      m_acc   = opd;
      m_carry = 1'b0;
    end else begin
      for (int i = 0; i <= rpt; i++) begin
        case (op)
          3'd0: m_acc = ~m_acc;
          3'd1: m_acc = m_acc & opd;
          3'd2: m_acc = m_acc;
          3'd3: m_acc = m_acc | opd;
          3'd4: begin m_carry = (m_acc == '0); m_acc = m_acc - 1; end
          3'd5: begin nxt = m_acc + opd; m_carry = (nxt < m_acc); m_acc = nxt; end
          3'd6: begin m_carry = (m_acc < opd); m_acc = m_acc - opd; end
          default: begin m_carry = (m_acc == '1); m_acc = m_acc + 1; end
        endcase
      end
    end
  endtask

  task automatic check_flags();
`ifdef CALC_SEQ_FLAGS_EN
    check("res_zero", W'(res_zero), W'(m_acc == '0));
    check("res_neg", W'(res_neg), W'(m_acc[W-1]));
`endif
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_cmd(input logic load, input logic [2:0] op, input logic [W-1:0] opd,
                         input int rpt, input int hold);
    int lat;
    logic [W-1:0] pre_acc;
    pre_acc = m_acc;
    check("cmd_ready_idle", W'(cmd_ready), W'(1));
    cmd_valid = 1'b1; cmd_load = load; cmd_opcode = op; cmd_operand = opd; cmd_rpt = 4'(rpt);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_load = 1'($urandom); cmd_opcode = 3'($urandom); cmd_operand = $urandom;
    cmd_rpt = 4'($urandom);
    model_cmd(load, op, opd, rpt);
    if (!load) begin
      check("exec_alu_opcode", W'(alu_opcode), W'(op));
      check("exec_alu_b", alu_b, opd);
      check("exec_alu_a", alu_a, pre_acc);
    end
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", W'(lat), load ? W'(1) : W'(rpt + 2));
    check("res_data", res_data, m_acc);
    check("res_carry", W'(res_carry), W'(m_carry));
    check("done_alu_opcode", W'(alu_opcode), W'(2));
    check("done_alu_b", alu_b, '0);
    check("done_cmd_ready", W'(cmd_ready), W'(0));
    check_flags();
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = $urandom;
      @(posedge clk); #1;
      check("stall_valid", W'(res_valid), W'(1));
      check("stall_data", res_data, m_acc);
      check("stall_carry", W'(res_carry), W'(m_carry));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("release_valid", W'(res_valid), W'(0));
    check("release_ready", W'(cmd_ready), W'(1));
    check("release_data", res_data, m_acc);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", W'(cmd_ready), W'(1));
    check("rst_res_valid", W'(res_valid), W'(0));
    check("rst_res_data", res_data, '0);
    check("rst_res_carry", W'(res_carry), W'(0));
    check("rst_alu_opcode", W'(alu_opcode), W'(2));
    check("rst_alu_b", alu_b, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a repeated ADD.
    run_cmd(1'b1, 3'd0, 32'd7, 0, 0);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opcode = 3'd5; cmd_operand = 32'd3; cmd_rpt = 4'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("midexec_state", W'(res_valid), W'(0));
    rst = 1'b1;
    #1;
    check("t1_cmd_ready", W'(cmd_ready), W'(1));
    check("t1_res_valid", W'(res_valid), W'(0));
    check("t1_res_data", res_data, '0);
    check("t1_res_carry", W'(res_carry), W'(0));
    check("t1_alu_opcode", W'(alu_opcode), W'(2));
    m_acc = '0; m_carry = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(1'b1, 3'd0, 32'd5, 0, 0);
    run_cmd(1'b0, 3'd5, 32'd3, 0, 0);
    check("t2_data", res_data, 32'd8);
    check("t2_carry", W'(res_carry), W'(0));

    run_cmd(1'b1, 3'd0, 32'hFFFF_FFFF, 0, 0);
    run_cmd(1'b0, 3'd7, 32'd0, 0, 0);
    check("t3_inc_data", res_data, 32'd0);
    check("t3_inc_carry", W'(res_carry), W'(1));
    run_cmd(1'b0, 3'd1, 32'hFFFF_FFFF, 0, 0);
    check("t3_and_data", res_data, 32'd0);
    check("t3_and_carry", W'(res_carry), W'(1));

    run_cmd(1'b1, 3'd0, 32'd10, 0, 0);
    run_cmd(1'b0, 3'd4, 32'd0, 3, 0);
    check("t4_dec_data", res_data, 32'd6);
    check("t4_dec_carry", W'(res_carry), W'(0));
    run_cmd(1'b1, 3'd0, 32'd0, 0, 0);
    run_cmd(1'b0, 3'd4, 32'd0, 0, 0);
    check("t4_wrap_data", res_data, 32'hFFFF_FFFF);
    check("t4_wrap_carry", W'(res_carry), W'(1));

    run_cmd(1'b1, 3'd0, 32'd3, 0, 0);
    run_cmd(1'b0, 3'd6, 32'd5, 0, 4);
    check("t5_sub_data", res_data, 32'hFFFF_FFFE);
    check("t5_sub_carry", W'(res_carry), W'(1));

`ifdef CALC_SEQ_FLAGS_EN
    run_cmd(1'b1, 3'd0, 32'h8000_0000, 0, 0);
    check("t6_neg", W'(res_neg), W'(1));
    check("t6_zero", W'(res_zero), W'(0));
    run_cmd(1'b0, 3'd6, 32'h8000_0000, 0, 0);
    check("t6_sub_zero", W'(res_zero), W'(1));
    check("t6_sub_neg", W'(res_neg), W'(0));
`endif

    run_cmd(1'b1, 3'd0, 32'd100, 0, 0);
    run_cmd(1'b0, 3'd5, 32'd1, 15, 1);
    check("max_rpt_data", res_data, 32'd116);

    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] opd;
      case ($urandom_range(0, 3))
        0: opd = 32'hFFFF_FFFF;
        1: opd = 32'($urandom_range(0, 8));
        default: opd = $urandom;
      endcase
      run_cmd(($urandom_range(0, 3) == 0), 3'($urandom), opd, $urandom_range(0, 15),
              $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
